// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: arbitrates the single register-file write port between
// the pipeline writeback stage (port A, fixed priority, no back-pressure) and a
// secondary multi-cycle unit (port B, valid/ready).
//
// Build option RF_ARB_STARVE_EN: when defined, port B gets a starvation grant
// after MAX_WAIT consecutive blocked cycles. The displaced pipeline write is
// parked in a one-entry hold register, and the pipeline is stalled for one cycle
// while the hold drains. When the macro is undefined, the block is pure fixed
// priority: no hold and no wait counter, stall_req=0 and proto_err=0.
module regfile_wr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             reg_wen,
    input  logic [4:0]       wr_reg,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             sec_valid,
    input  logic [4:0]       sec_reg,
    input  logic [WIDTH-1:0] sec_data,
    output logic             sec_ready,
    output logic             rf_wen,
    output logic [4:0]       rf_wr_reg,
    output logic [WIDTH-1:0] rf_wr_data,
    output logic             stall_req,
    output logic             proto_err
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("MAX_WAIT must be in 1..15");
    end

    typedef struct packed {
        logic [4:0]       rg;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t  a_wr, b_wr, rf_q, nxt_wr;
    logic nxt_wen;

    assign a_wr = '{rg: wr_reg,  data: alu_result};
    assign b_wr = '{rg: sec_reg, data: sec_data};

`ifdef RF_ARB_STARVE_EN
    wr_t        hold_q;
    logic       hold_valid, nxt_hold_valid, capture;
    logic [3:0] wait_cnt, nxt_wait;
    logic       err_q, nxt_err;
    logic       starve;

    assign starve = (wait_cnt == 4'(MAX_WAIT));

    // Grant selection: a pending hold has first priority, then port A, and then
    // port B (either in an idle slot or by a starvation grant that parks A).
    always_comb begin
        sec_ready      = rst_n && !hold_valid && (!reg_wen || starve);
        nxt_wen        = 1'b0;
        nxt_wr         = rf_q;
        nxt_hold_valid = hold_valid;
        nxt_err        = err_q;
        capture        = 1'b0;
        if (hold_valid) begin
            nxt_wen        = 1'b1;
            nxt_wr         = hold_q;
            nxt_hold_valid = 1'b0;
            if (reg_wen) nxt_err = 1'b1;   // pipeline ignored the stall; its write is dropped
        end else if (reg_wen && (!starve || !sec_valid)) begin
            nxt_wen = 1'b1;
            nxt_wr  = a_wr;
        end else if (reg_wen) begin
            nxt_wen        = 1'b1;
            nxt_wr         = b_wr;
            nxt_hold_valid = 1'b1;
            capture        = 1'b1;
        end else if (sec_valid) begin
            nxt_wen = 1'b1;
            nxt_wr  = b_wr;
        end
        if (!sec_valid || sec_ready)
            nxt_wait = 4'd0;
        else if (!starve)
            nxt_wait = wait_cnt + 4'd1;
        else
            nxt_wait = wait_cnt;
    end

    // Hold entry, starvation counter and sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_q     <= '0;
            wait_cnt   <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            hold_valid <= nxt_hold_valid;
            if (capture) hold_q <= a_wr;
            wait_cnt   <= nxt_wait;
            err_q      <= nxt_err;
        end
    end

    assign stall_req = hold_valid;
    assign proto_err = err_q;
`else
    // Pure fixed priority: port A always wins, and port B uses only idle slots.
    always_comb begin
        sec_ready = rst_n && !reg_wen;
        nxt_wen   = 1'b0;
        nxt_wr    = rf_q;
        if (reg_wen) begin
            nxt_wen = 1'b1;
            nxt_wr  = a_wr;
        end else if (sec_valid) begin
            nxt_wen = 1'b1;
            nxt_wr  = b_wr;
        end
    end

    assign stall_req = 1'b0;
    assign proto_err = 1'b0;
`endif

    // Registered register-file write port. Address and data keep their last
    // values in idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen <= 1'b0;
            rf_q   <= '0;
        end else begin
            rf_wen <= nxt_wen;
            rf_q   <= nxt_wr;
        end
    end

    assign rf_wr_reg  = rf_q.rg;
    assign rf_wr_data = rf_q.data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter. The driver applies directed and random
// stimulus and pushes the expected registered result of each cycle into a
// scoreboard queue. A separate monitor pops the queue and compares it after
// every rising edge. The model follows whichever build option is compiled.
module tb_regfile_wr_arbiter;
`ifdef RF_ARB_STARVE_EN
    localparam bit STARVE = 1'b1;
`else
    localparam bit STARVE = 1'b0;
`endif
    localparam int WIDTH    = 8;
    localparam int MAX_WAIT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             reg_wen = 1'b0, sec_valid = 1'b0;
    logic [4:0]       wr_reg = '0, sec_reg = '0;
    logic [WIDTH-1:0] alu_result = '0, sec_data = '0;
    logic             sec_ready, rf_wen, stall_req, proto_err;
    logic [4:0]       rf_wr_reg;
    logic [WIDTH-1:0] rf_wr_data;

    regfile_wr_arbiter #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .reg_wen(reg_wen), .wr_reg(wr_reg), .alu_result(alu_result),
        .sec_valid(sec_valid), .sec_reg(sec_reg), .sec_data(sec_data),
        .sec_ready(sec_ready), .rf_wen(rf_wen), .rf_wr_reg(rf_wr_reg),
        .rf_wr_data(rf_wr_data), .stall_req(stall_req), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       wen;
        bit [4:0] rg;
        bit [7:0] data;
        bit       stall;
        bit       err;
    } exp_t;

    exp_t q[$];
    int   nvec = 0, nbad = 0;

    // Reference state: the parked pipeline write, the blocked-cycle count, and the sticky error.
    bit       m_hv, m_err, last_ready;
    bit [4:0] m_hreg;
    bit [7:0] m_hdata;
    int       m_wait;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_hv = 0; m_err = 0; m_wait = 0; m_hreg = '0; m_hdata = '0; last_ready = 0;
    endtask

    // One cycle. Inputs are applied at the falling edge, and sec_ready is checked
    // right after. The result expected at the next rising edge is queued.
    task automatic step(input bit a, input bit [4:0] ar, input bit [7:0] ad,
                        input bit b, input bit [4:0] br, input bit [7:0] bd);
        exp_t e;
        bit   rdy, starve;
        @(negedge clk);
        reg_wen = a; wr_reg = ar; alu_result = ad;
        sec_valid = b; sec_reg = br; sec_data = bd;
        starve = (m_wait == MAX_WAIT);
        rdy = STARVE ? (!m_hv && (!a || starve)) : !a;
        #1 chk("sec_ready", sec_ready, rdy);
        e = '{default: 0};
        if (STARVE && m_hv) begin
            e.wen = 1; e.rg = m_hreg; e.data = m_hdata;
            m_hv = 0;
            if (a) m_err = 1;
        end else if (a && (!STARVE || !starve || !b)) begin
            e.wen = 1; e.rg = ar; e.data = ad;
        end else if (a) begin
            e.wen = 1; e.rg = br; e.data = bd;
            m_hv = 1; m_hreg = ar; m_hdata = ad;
        end else if (b) begin
            e.wen = 1; e.rg = br; e.data = bd;
        end
        if (STARVE) begin
            if (!b || rdy) m_wait = 0;
            else if (m_wait < MAX_WAIT) m_wait++;
        end
        e.stall = m_hv;
        e.err   = m_err;
        q.push_back(e);
        last_ready = rdy;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    // Apply reset asynchronously with both ports active, and check that everything reads back zero.
    task automatic do_reset();
        @(negedge clk);
        reg_wen = 1; sec_valid = 1; wr_reg = 5'd4; alu_result = 8'hEE;
        rst_n = 0;
        q.delete();
        model_clear();
        #1;
        chk("rst rf_wen", rf_wen, 0);
        chk("rst rf_wr_reg", rf_wr_reg, 0);
        chk("rst rf_wr_data", rf_wr_data, 0);
        chk("rst stall_req", stall_req, 0);
        chk("rst proto_err", proto_err, 0);
        chk("rst sec_ready", sec_ready, 0);
        repeat (2) @(negedge clk);
        reg_wen = 0; sec_valid = 0;
        rst_n = 1;
    endtask

    // Drive starvation: the pipeline writes every cycle while port B waits, until B is granted and the hold drains.
    task automatic starve_run(input bit [4:0] a_reg, input bit [7:0] a_dat, input bit same_reg,
                              input bit [4:0] br, input bit [7:0] bd, input bit violate);
        bit pend = 1;
        for (int i = 0; i < 10; i++) begin
            if (m_hv && violate) step(1, a_reg, 8'hC3, pend, br, bd);
            else step(!m_hv, same_reg ? a_reg : 5'(i + 1), a_dat, pend, br, bd);
            if (pend && last_ready) pend = 0;
        end
    endtask

    task automatic random_run(input int n);
        bit       pb = 0;
        bit [4:0] pbr;
        bit [7:0] pbd;
        bit       a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 3) != 0);
            if (m_hv) a = 0;
            if (!pb) begin
                pb  = ($urandom_range(0, 1) == 1);
                pbr = 5'($urandom);
                pbd = 8'($urandom);
            end
            step(a, 5'($urandom), 8'($urandom), pb, pbr, pbd);
            if (pb && last_ready) pb = 0;
        end
    endtask

    // Monitor: compare the registered outputs with the queued expectation after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rf_wen", rf_wen, e.wen);
                if (e.wen) begin
                    chk("rf_wr_reg", rf_wr_reg, e.rg);
                    chk("rf_wr_data", rf_wr_data, e.data);
                end
                chk("stall_req", stall_req, e.stall);
                chk("proto_err", proto_err, e.err);
            end
        end
    end

    initial begin
        model_clear();
        reg_wen = 1; sec_valid = 1;
        #2;
        chk("init rf_wen", rf_wen, 0);
        chk("init sec_ready", sec_ready, 0);
        chk("init stall_req", stall_req, 0);
        @(negedge clk);
        reg_wen = 0; sec_valid = 0;
        rst_n = 1;

        // Port A only, with port B waiting.
        step(1, 5'd3, 8'h5A, 1, 5'd7, 8'h11);
        step(1, 5'd3, 8'h5A, 1, 5'd7, 8'h11);
        // Port B in an idle slot.
        step(0, 5'd0, 8'h00, 1, 5'd7, 8'h11);
        idle(2);
        // Starvation grant, with distinct registers.
        starve_run(5'd1, 8'h40, 0, 5'd9, 8'hAB, 0);
        // Same-register collision: B's value lands first, then A's.
        starve_run(5'd5, 8'h33, 1, 5'd5, 8'h22, 0);
        // Protocol violation while stalled.
        starve_run(5'd6, 8'h44, 1, 5'd10, 8'h55, 1);
        idle(2);
        // Long pipeline burst against a waiting port B.
        for (int i = 0; i < 20; i++) step(!m_hv, 5'(i), 8'(i * 3), 1, 5'd12, 8'h77);
        idle(2);
        random_run(300);
        do_reset();
        random_run(300);
        idle(3);
        @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the single register-file write port between the pipeline writeback stage (port A, primary, no back-pressure) and a secondary multi-cycle unit (port B, valid/ready). Sits between the writeback stage outputs and the register file write inputs. Fixed priority to the pipeline, with a starvation guard: port B can borrow a slot, and the displaced pipeline write is parked in a one-entry hold register while the pipeline is stalled for one cycle.

## Interface
- WIDTH, 8, data width of register writes
- MAX_WAIT, 4, number of consecutive blocked cycles on port B before the starvation grant (1..15)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- reg_wen  in  1  port A write enable (from writeback stage)
- wr_reg  in  5  port A destination register
- alu_result  in  WIDTH  port A write data
- sec_valid  in  1  port B write request
- sec_reg  in  5  port B destination register
- sec_data  in  WIDTH  port B write data
- sec_ready  out  1  port B accept (combinational)
- rf_wen  out  1  register-file write enable (registered)
- rf_wr_reg  out  5  register-file write address (registered)
- rf_wr_data  out  WIDTH  register-file write data (registered)
- stall_req  out  1  pipeline must present reg_wen=0 this cycle
- proto_err  out  1  sticky: pipeline wrote while stall_req=1

## Operation
- State: hold_valid, hold_reg[4:0], hold_data, wait_cnt[3:0], proto_err.
- starve = (wait_cnt == MAX_WAIT).
- Per-cycle grant, in priority order:
  1. hold_valid=1: hold entry goes to rf; hold_valid<=0; sec_ready=0. If reg_wen=1, set proto_err and drop the port A write.
  2. reg_wen=1 and starve=0: port A goes to rf; sec_ready=0.
  3. reg_wen=1, starve=1, sec_valid=1: port B goes to rf; sec_ready=1; port A captured into hold (hold_valid<=1).
  4. reg_wen=0: sec_ready=1; port B goes to rf if sec_valid=1, otherwise rf_wen<=0.
- sec_ready = !hold_valid && (!reg_wen || starve). It is 0 while rst_n=0.
- wait_cnt:
  - Cleared on a B transfer (sec_valid && sec_ready) or when sec_valid=0.
  - Incremented (saturating at MAX_WAIT) when sec_valid=1 and sec_ready=0.
- stall_req = hold_valid.
- Port B must hold sec_reg and sec_data stable while sec_valid=1 and sec_ready=0.
- Same-register collision in case 3: the B write lands first, then the held A write. The A value is final.

## Timing
- Reset values: rf_wen=0, rf_wr_reg=0, rf_wr_data=0, stall_req=0, proto_err=0, hold_valid=0, wait_cnt=0. Async reset mid-operation discards any held write.
- Latency: the winning write appears on rf_* one cycle after it is presented.
- A starvation grant costs exactly one pipeline stall cycle:
  - cycle N: B granted.
  - cycle N+1: stall_req=1; the hold is written to rf in cycle N+2.
- After a stall, wait_cnt is 0. A new B request needs MAX_WAIT more blocked cycles before it is granted over port A.
- proto_err clears only on reset.

## Configuration
- RF_ARB_STARVE_EN defined: starvation guard as above.
- Not defined:
  - Pure fixed priority. wait_cnt and hold are removed, stall_req is tied 0, and proto_err is tied 0.
  - sec_ready = !reg_wen. Port B may starve indefinitely.

## Test plan
- Reset: assert rst_n=0 mid-burst with reg_wen=1 -> all outputs 0, sec_ready=0. Release -> first rf write one cycle after next input.
- A only: reg_wen=1, wr_reg=3, alu_result=0x5A -> next cycle rf_wen=1, rf_wr_reg=3, rf_wr_data=0x5A. sec_ready stays 0 while sec_valid=1.
- B in idle: reg_wen=0, sec_valid=1, sec_reg=7, sec_data=0x11 -> sec_ready=1. Next cycle rf writes r7=0x11. wait_cnt stays 0.
- Starvation (MAX_WAIT=4): continuous reg_wen=1 (r1..), sec_valid=1 (r9=0xAB) -> 4 blocked cycles. On the 5th, B is granted and rf writes r9=0xAB. The next cycle has stall_req=1. The held A write lands one cycle after that. No A write is lost.
- Collision: starve grant with sec_reg=wr_reg=5, sec_data=0x22, alu_result=0x33 -> r5=0x22, then r5=0x33.
- Violation: drive reg_wen=1 while stall_req=1 -> proto_err=1 (sticky). That A write does not reach rf.
- Without RF_ARB_STARVE_EN: 20 cycles of reg_wen=1 with sec_valid=1 -> sec_ready never asserts, stall_req=0.
